// File: rtl/magia_tile_eoc_ctrl.sv
// Multi-tile end-of-computation controller: staggered per-tile boot, per-tile
// memory-mapped EXIT / cycle-counter window, done aggregation and run timeout.

module magia_tile_eoc_chan #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [ADDR_W-1:0] EOC_BASE = 32'hCC00_0000
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              req_valid_i,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   input  logic              fetch_en_i,
   input  logic [63:0]       cyc_i,
   output logic              rsp_valid_o,
   output logic              rsp_err_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              exit_wr_o,
   output logic              done_o,
   output logic [DATA_W-1:0] code_o
);
   logic              hit;
   logic [3:0]        off;
   logic              ok;
   logic [DATA_W-1:0] rdata;

   assign hit = (req_addr_i[ADDR_W-1:4] == EOC_BASE[ADDR_W-1:4]);
   assign off = req_addr_i[3:0];

   always_comb begin
      ok    = 1'b0;
      rdata = '0;
      if (hit) begin
         if (req_we_i) begin
            ok = (off == 4'h0) && fetch_en_i;
         end else begin
            case (off)
               4'h0:    begin ok = 1'b1; rdata = code_o;       end
               4'h4:    begin ok = 1'b1; rdata = cyc_i[31:0];  end
               4'h8:    begin ok = 1'b1; rdata = cyc_i[63:32]; end
               default: ok = 1'b0;
            endcase
         end
      end
   end

   // only the first EXIT write of a run is recorded; later ones are acked and dropped
   assign exit_wr_o = req_valid_i && req_we_i && ok && !done_o;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_rdata_o <= '0;
         done_o      <= 1'b0;
         code_o      <= '0;
      end else begin
         rsp_valid_o <= req_valid_i;
         rsp_err_o   <= req_valid_i && !ok;
         rsp_rdata_o <= req_valid_i ? rdata : '0;
         if (clr_i) begin
            done_o <= 1'b0;
            code_o <= '0;
         end else if (exit_wr_o) begin
            done_o <= 1'b1;
            code_o <= req_wdata_i;
         end
      end
   end
endmodule

module magia_tile_eoc_ctrl #(
   parameter int unsigned       N_TILES        = 4,
   parameter int unsigned       ADDR_W         = 32,
   parameter int unsigned       DATA_W         = 32,
   parameter logic [ADDR_W-1:0] EOC_BASE       = 32'hCC00_0000,
   parameter int unsigned       BOOT_STAGGER   = 0,
   parameter int unsigned       TIMEOUT_CYCLES = 1000000
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        start_i,
   input  logic [N_TILES-1:0]          req_valid_i,
   input  logic [N_TILES-1:0]          req_we_i,
   input  logic [N_TILES*ADDR_W-1:0]   req_addr_i,
   input  logic [N_TILES*DATA_W-1:0]   req_wdata_i,
   output logic [N_TILES-1:0]          req_ready_o,
   output logic [N_TILES-1:0]          rsp_valid_o,
   output logic [N_TILES-1:0]          rsp_err_o,
   output logic [N_TILES*DATA_W-1:0]   rsp_rdata_o,
   output logic [N_TILES-1:0]          fetch_enable_o,
   output logic [N_TILES-1:0]          tile_done_o,
   output logic                        all_done_o,
   output logic                        timeout_o,
   output logic [31:0]                 exit_code_o,
   output logic                        busy_o
);
   typedef enum logic [2:0] {IDLE, BOOT, RUN, DONE, TIMEOUT} state_e;

   state_e                           state;
   logic [N_TILES-1:0]               fe;
   logic [N_TILES-1:0]               fe_at_start;
   logic [N_TILES-1:0]               boot_hit;
   logic [N_TILES-1:0]               exit_wr;
   logic [N_TILES-1:0]               not_done;
   logic [N_TILES-1:0][DATA_W-1:0]   codes;
   logic [31:0]                      boot_cnt;
   logic [31:0]                      run_cnt;
   logic [63:0]                      cyc;
   logic                             start_ok;

   assign start_ok = start_i && (state == IDLE || state == DONE || state == TIMEOUT);

   for (genvar g = 0; g < N_TILES; g++) begin : g_tile
      assign fe_at_start[g] = (BOOT_STAGGER == 0) || (g == 0);
      assign boot_hit[g]    = (boot_cnt == 32'(g * BOOT_STAGGER));

      magia_tile_eoc_chan #(
         .ADDR_W   (ADDR_W),
         .DATA_W   (DATA_W),
         .EOC_BASE (EOC_BASE)
      ) u_chan (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .clr_i       (start_ok),
         .req_valid_i (req_valid_i[g]),
         .req_we_i    (req_we_i[g]),
         .req_addr_i  (req_addr_i[g*ADDR_W +: ADDR_W]),
         .req_wdata_i (req_wdata_i[g*DATA_W +: DATA_W]),
         .fetch_en_i  (fe[g]),
         .cyc_i       (cyc),
         .rsp_valid_o (rsp_valid_o[g]),
         .rsp_err_o   (rsp_err_o[g]),
         .rsp_rdata_o (rsp_rdata_o[g*DATA_W +: DATA_W]),
         .exit_wr_o   (exit_wr[g]),
         .done_o      (tile_done_o[g]),
         .code_o      (codes[g])
      );
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state      <= IDLE;
         fe         <= '0;
         boot_cnt   <= '0;
         run_cnt    <= '0;
         cyc        <= '0;
         all_done_o <= 1'b0;
      end else begin
         all_done_o <= &tile_done_o;
         case (state)
            IDLE, DONE, TIMEOUT: begin
               if (start_i) begin
                  state      <= BOOT;
                  fe         <= fe_at_start;
                  boot_cnt   <= 32'd1;
                  run_cnt    <= '0;
                  cyc        <= '0;
                  all_done_o <= 1'b0;
               end
            end
            BOOT: begin
               cyc      <= cyc + 64'd1;
               boot_cnt <= boot_cnt + 32'd1;
               fe       <= fe | boot_hit;
               if (&fe) state <= RUN;
            end
            RUN: begin
               cyc     <= cyc + 64'd1;
               run_cnt <= run_cnt + 32'd1;
               // an EXIT landing on the limit cycle completes the set, so DONE beats TIMEOUT
               if (&tile_done_o)
                  state <= DONE;
               else if (TIMEOUT_CYCLES != 0 && run_cnt == TIMEOUT_CYCLES &&
                        !(&(tile_done_o | exit_wr)))
                  state <= TIMEOUT;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready_o    = '1;
   assign fetch_enable_o = fe;
   assign busy_o         = (state == BOOT) || (state == RUN);
   assign timeout_o      = (state == TIMEOUT);
   assign not_done       = ~tile_done_o;

   always_comb begin
      exit_code_o = '0;
      if (state == DONE) begin
         for (int i = int'(N_TILES) - 1; i >= 0; i--)
            if (codes[i] != '0) exit_code_o = codes[i];
      end else if (state == TIMEOUT) begin
         exit_code_o = {16'hDEAD, 16'(not_done)};
      end
   end
endmodule

// File: tb/tb_magia_tile_eoc_ctrl.sv
// Bench for magia_tile_eoc_ctrl: event-time reference model checked every cycle,
// directed boot/done/timeout/error/reset sequences, then randomized runs.

module tb_magia_tile_eoc_ctrl;
   localparam int N = 4;
   localparam int S = 3;
   localparam int T = 100;
   localparam logic [31:0] BASE = 32'hCC00_0000;

   logic                 clk = 1'b0;
   logic                 rst_n, start;
   logic [N-1:0]         rv, rwe;
   logic [N-1:0][31:0]   raddr, rwdata;
   logic [N-1:0]         ready, rsp_v, rsp_e, fe, tdone;
   logic [N-1:0][31:0]   rdata;
   logic                 all_done, tmo, busy;
   logic [31:0]          ecode;

   always #5 clk = ~clk;

   magia_tile_eoc_ctrl #(
      .N_TILES(N), .ADDR_W(32), .DATA_W(32), .EOC_BASE(BASE),
      .BOOT_STAGGER(S), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start),
      .req_valid_i(rv), .req_we_i(rwe), .req_addr_i(raddr), .req_wdata_i(rwdata),
      .req_ready_o(ready), .rsp_valid_o(rsp_v), .rsp_err_o(rsp_e), .rsp_rdata_o(rdata),
      .fetch_enable_o(fe), .tile_done_o(tdone), .all_done_o(all_done),
      .timeout_o(tmo), .exit_code_o(ecode), .busy_o(busy)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: the run is described by the edge numbers at which things happened.
   int                 n = 0;       // number of clock edges so far
   int                 t0 = -1;     // edge that sampled the accepted start
   int                 t_end = -1;  // edge at which the run finished (done or timeout)
   bit                 to = 1'b0;
   int                 done_t[N];   // edge at which each tile's EXIT was accepted
   logic [N-1:0][31:0] code_m;
   logic [N-1:0]       exp_rv, exp_re;
   logic [N-1:0][31:0] exp_rd;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, n, act, exp);
      end
   endtask

   function automatic void model_clear();
      t_end = -1;
      to = 1'b0;
      for (int i = 0; i < N; i++) begin
         done_t[i] = -1;
         code_m[i] = '0;
      end
   endfunction

   function automatic bit fe_m(int i, int k);
      return t0 >= 0 && k >= t0 + i * S;
   endfunction

   function automatic bit busy_m(int k);
      return t0 >= 0 && k >= t0 && (t_end < 0 || k < t_end);
   endfunction

   function automatic logic [63:0] cyc_m(int k);
      int e;
      if (t0 < 0) return 64'd0;
      e = (t_end >= 0 && t_end <= k) ? t_end : k;
      return 64'(e - t0);
   endfunction

   function automatic bit all_done_m(int k);
      int dl = -1;
      for (int i = 0; i < N; i++) begin
         if (done_t[i] < 0) return 1'b0;
         if (done_t[i] > dl) dl = done_t[i];
      end
      return k >= dl + 1;
   endfunction

   function automatic logic [31:0] exit_m(int k);
      logic [N-1:0] nd;
      if (t_end < 0 || k < t_end) return 32'd0;
      if (to) begin
         for (int i = 0; i < N; i++) nd[i] = (done_t[i] < 0);
         return 32'hDEAD_0000 | 32'(nd);
      end
      for (int i = 0; i < N; i++)
         if (code_m[i] != 32'd0) return code_m[i];
      return 32'd0;
   endfunction

   task automatic compare_all();
      logic [N-1:0] fe_e, dn_e;
      for (int i = 0; i < N; i++) begin
         fe_e[i] = fe_m(i, n);
         dn_e[i] = (done_t[i] >= 0);
      end
      chk("req_ready", ready, {N{1'b1}});
      chk("fetch_enable", fe, fe_e);
      chk("tile_done", tdone, dn_e);
      chk("all_done", all_done, all_done_m(n));
      chk("timeout", tmo, to && t_end >= 0 && n >= t_end);
      chk("busy", busy, busy_m(n));
      chk("exit_code", ecode, exit_m(n));
      chk("rsp_valid", rsp_v, exp_rv);
      chk("rsp_err", rsp_e & exp_rv, exp_re);
      for (int i = 0; i < N; i++)
         if (exp_rv[i]) chk($sformatf("rsp_rdata%0d", i), rdata[i], exp_rd[i]);
   endtask

   // One clock: predict the edge from the model, clock it, compare on the falling edge.
   task automatic tick();
      int a = n + 1;
      int k = n;
      bit restart, ok, alld;
      int R, dl;
      logic [31:0] rd;
      logic [3:0] off;
      if (!rst_n) begin
         t0 = -1;
         model_clear();
         exp_rv = '0; exp_re = '0; exp_rd = '0;
      end else begin
         restart = start && !busy_m(k);
         for (int i = 0; i < N; i++) begin
            exp_rv[i] = rv[i]; exp_re[i] = 1'b0; exp_rd[i] = '0;
            if (rv[i]) begin
               ok = 1'b0; rd = '0; off = raddr[i][3:0];
               if (raddr[i][31:4] == BASE[31:4]) begin
                  if (rwe[i]) ok = (off == 4'h0) && fe_m(i, k);
                  else if (off == 4'h0) begin ok = 1'b1; rd = code_m[i]; end
                  else if (off == 4'h4) begin ok = 1'b1; rd = cyc_m(k)[31:0]; end
                  else if (off == 4'h8) begin ok = 1'b1; rd = cyc_m(k)[63:32]; end
               end
               exp_re[i] = !ok;
               exp_rd[i] = (ok && !rwe[i]) ? rd : 32'd0;
               if (rwe[i] && ok && done_t[i] < 0) begin
                  done_t[i] = a;
                  code_m[i] = rwdata[i];
               end
            end
         end
         if (restart) begin
            model_clear();
            t0 = a;
         end else if (t0 >= 0 && t_end < 0) begin
            R = t0 + (N - 1) * S + 1;
            alld = 1'b1; dl = -1;
            for (int i = 0; i < N; i++) begin
               if (done_t[i] < 0) alld = 1'b0;
               if (done_t[i] > dl) dl = done_t[i];
            end
            if (alld && dl + 1 == a) begin
               t_end = a; to = 1'b0;
            end else if (a == R + T + 1 && !(alld && dl <= a)) begin
               t_end = a; to = 1'b1;
            end
         end
      end
      @(posedge clk);
      n = a;
      @(negedge clk);
      compare_all();
      start = 1'b0; rv = '0; rwe = '0;
   endtask

   task automatic wr_exit(int i, logic [31:0] v);
      rv[i] = 1'b1; rwe[i] = 1'b1; raddr[i] = BASE; rwdata[i] = v;
   endtask

   task automatic rd_reg(int i, logic [3:0] off);
      rv[i] = 1'b1; rwe[i] = 1'b0; raddr[i] = BASE | 32'(off); rwdata[i] = '0;
   endtask

   task automatic wait_idle(string name, int budget);
      int c = 0;
      while (busy && c < budget) begin
         tick();
         c++;
      end
      chk(name, busy, 1'b0);
   endtask

   task automatic rand_req(int i, int r);
      logic [31:0] a;
      logic w;
      int sel;
      w = 1'($urandom % 2);
      sel = int'($urandom % 4);
      if ($urandom % 8 == 0) a = $urandom;
      else a = BASE | ((sel == 0) ? 32'h0 : (sel == 1) ? 32'h4 : (sel == 2) ? 32'h8 : ($urandom % 16));
      if (w && a[31:4] == BASE[31:4] && a[3:0] == 4'h0)
         if (!busy_m(n) || (r % 2 == 1 && $urandom % 10 != 0)) w = 1'b0;
      rv[i] = 1'b1; rwe[i] = w; raddr[i] = a; rwdata[i] = $urandom % 4;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int rise[N];
      logic [31:0] rd1;

      tbl[0]  = '{1'b0, BASE | 32'hC, 32'h0, 1'b1};
      tbl[1]  = '{1'b0, BASE | 32'h2, 32'h0, 1'b1};
      tbl[2]  = '{1'b0, BASE + 32'h10, 32'h0, 1'b1};
      tbl[3]  = '{1'b0, 32'h1000_0000, 32'h0, 1'b1};
      tbl[4]  = '{1'b1, BASE | 32'h4, 32'h3, 1'b1};
      tbl[5]  = '{1'b1, BASE | 32'h8, 32'h3, 1'b1};
      tbl[6]  = '{1'b1, BASE | 32'hC, 32'h3, 1'b1};
      tbl[7]  = '{1'b1, BASE | 32'h1, 32'h3, 1'b1};
      tbl[8]  = '{1'b1, BASE + 32'h100, 32'h3, 1'b1};
      tbl[9]  = '{1'b0, BASE, 32'h0, 1'b0};
      tbl[10] = '{1'b0, BASE | 32'h4, 32'h0, 1'b0};
      tbl[11] = '{1'b0, BASE | 32'h8, 32'h0, 1'b0};

      rst_n = 1'b0; start = 1'b0; rv = '0; rwe = '0; raddr = '0; rwdata = '0;
      model_clear();
      repeat (3) tick();
      chk("reset_outputs", {rsp_v, fe, tdone, all_done, tmo, busy, ecode}, 64'd0);
      rst_n = 1'b1;
      while (n < 10) tick();

      // staggered boot: tile i enables i*S edges after the edge that sampled start
      start = 1'b1;
      tick();
      s = n;
      chk("busy_at_boot", busy, 1'b1);
      for (int i = 0; i < N; i++) rise[i] = -1;
      for (int c = 0; c <= 12; c++) begin
         for (int i = 0; i < N; i++)
            if (fe[i] && rise[i] < 0) rise[i] = n - s;
         if (c < 12) tick();
      end
      for (int i = 0; i < N; i++) chk($sformatf("fe_rise%0d", i), 64'(rise[i]), 64'(i * S));

      // all tiles exit with 0 at staggered times
      wr_exit(0, 0); tick();
      chk("done0_next_cycle", tdone[0], 1'b1);
      tick(); tick();
      wr_exit(1, 0); tick(); tick();
      wr_exit(2, 0); tick(); tick(); tick();
      wr_exit(3, 0); tick();
      chk("done_flags_all", tdone, 4'hF);
      chk("all_done_lags", all_done, 1'b0);
      tick();
      chk("all_done_set", all_done, 1'b1);
      chk("idle_after_done", busy, 1'b0);
      chk("exit_zero", ecode, 32'd0);
      rd_reg(0, 4'h4); tick();
      rd1 = rdata[0];
      chk("cyc_frozen_1", rd1, 64'(t_end - t0));
      repeat (3) tick();
      rd_reg(0, 4'h4); tick();
      chk("cyc_frozen_2", rdata[0], 64'(t_end - t0));

      // simultaneous EXITs, lowest nonzero wins, second EXIT ignored
      start = 1'b1; tick();
      repeat (10) tick();
      wr_exit(0, 0); wr_exit(1, 0); wr_exit(2, 5); wr_exit(3, 7); tick();
      chk("same_cycle_done", tdone, 4'hF);
      tick();
      chk("exit_code_5", ecode, 32'd5);
      wr_exit(2, 9); tick();
      chk("rewrite_ok_valid", rsp_v[2], 1'b1);
      chk("rewrite_ok_err", rsp_e[2], 1'b0);
      rd_reg(2, 4'h0); tick();
      chk("stored_code_kept", rdata[2], 32'd5);
      chk("exit_code_kept", ecode, 32'd5);

      // timeout run with error-path table on tile 1
      start = 1'b1; tick();
      wr_exit(3, 1); tick();
      chk("early_exit_err", rsp_e[3], 1'b1);
      chk("early_exit_no_done", tdone[3], 1'b0);
      repeat (10) tick();
      wr_exit(0, 2); wr_exit(2, 0); tick();
      foreach (tbl[j]) begin
         rv[1] = 1'b1; rwe[1] = tbl[j].we; raddr[1] = tbl[j].addr; rwdata[1] = tbl[j].wdata;
         tick();
         chk($sformatf("tbl%0d_err", j), rsp_e[1], tbl[j].exp_err);
         if (tbl[j].exp_err) chk($sformatf("tbl%0d_rdata", j), rdata[1], 32'd0);
         chk($sformatf("tbl%0d_done_kept", j), tdone[1], 1'b0);
      end
      wait_idle("timeout_reached", 300);
      chk("timeout_flag", tmo, 1'b1);
      chk("timeout_code", ecode, 32'hDEAD_000A);
      chk("timeout_done_mask", tdone, 4'b0101);

      // reset mid-run with a response in flight
      start = 1'b1; tick();
      repeat (12) tick();
      rd_reg(0, 4'h4);
      rst_n = 1'b0; tick();
      chk("midrun_reset", {rsp_v, fe, tdone, all_done, tmo, busy, ecode}, 64'd0);
      rst_n = 1'b1; tick();
      start = 1'b1; tick();
      chk("reboot_fe0", fe[0], 1'b1);
      chk("reboot_busy", busy, 1'b1);
      repeat (10) tick();
      for (int i = 0; i < N; i++) wr_exit(i, 32'(i));
      tick();
      wait_idle("reboot_done", 50);
      chk("reboot_exit", ecode, 32'd1);

      // randomized runs; odd runs rarely exit so they tend to time out
      for (int r = 0; r < 10; r++) begin
         start = 1'b1; tick();
         for (int c = 0; c < 260 && (busy || c < 5); c++) begin
            for (int i = 0; i < N; i++)
               if ($urandom % 3 == 0) rand_req(i, r);
            if ($urandom % 60 == 0) start = 1'b1;
            if ($urandom % 400 == 0) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
